spike_interval_meter: RTL and testbench

- Downstream consumer of one LIF neuron's spike output in the CPG network.
- Measures the inter-spike interval (ISI) in clock cycles and queues each ISI in a small FIFO, read through a valid/ready handshake.
- Also reports the spike count per fixed window.
- Feeds the gait/phase controller and the debug readout with neuron firing rate and rhythm.

---
 rtl/spike_interval_meter.sv | 168 ++++++++++++++++
 tb/tb_spike_interval_meter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_interval_meter.sv
// Measures inter-spike intervals of one neuron into a small FIFO and counts spikes per fixed window.
// Define ISI_REFRACT_EN to add min_isi / rejected_cnt refractory filtering of too-short intervals.

module spike_interval_meter #(
   parameter int ISI_W      = 16,
   parameter int DEPTH      = 4,
   parameter int WIN_CYCLES = 1000,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spike,
   output logic [ISI_W-1:0] isi_data,
   output logic             isi_valid,
   input  logic             isi_ready,
   output logic [CNT_W-1:0] spike_count,
   output logic             rate_valid,
   output logic             ovf,
   input  logic             clr_ovf,
`ifdef ISI_REFRACT_EN
   input  logic [ISI_W-1:0] min_isi,
   output logic [7:0]       rejected_cnt,
`endif
   output logic             armed
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state_q, state_d;
   logic             spike_q;
   logic [ISI_W-1:0] isiCnt_q, isiCnt_d, isiNext;
   logic [ISI_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic [WIN_W-1:0] winCnt_q;
   logic [CNT_W-1:0] acc_q, accNext, spikeCount_q;
   logic             rateValid_q, ovf_q, armed_q;
   logic             spikeEdge, tooShort, push, accept, full, pop, wrEn, drop;

   assign spikeEdge = spike & ~spike_q;
   assign isiNext   = (isiCnt_q == '1) ? isiCnt_q : isiCnt_q + ISI_W'(1);

`ifdef ISI_REFRACT_EN
   logic [7:0] rejCnt_q;
   logic       rejectEdge;

   assign tooShort     = isiNext < min_isi;
   assign rejectEdge   = (state_q == MEASURE) & spikeEdge & tooShort;
   assign rejected_cnt = rejCnt_q;

   always_ff @(posedge clk) begin
      if (!reset)
         rejCnt_q <= '0;
      else if (rejectEdge && rejCnt_q != 8'hFF)
         rejCnt_q <= rejCnt_q + 8'd1;
   end
`else
   assign tooShort = 1'b0;
`endif

   // A rejected edge leaves the counter running so the next interval is measured from the last accepted spike.
   always_comb begin
      state_d  = state_q;
      isiCnt_d = isiCnt_q;
      push     = 1'b0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (spikeEdge) begin
               isiCnt_d = '0;
               state_d  = MEASURE;
               accept   = 1'b1;
            end
         end
         MEASURE: begin
            if (spikeEdge && !tooShort) begin
               push     = 1'b1;
               accept   = 1'b1;
               isiCnt_d = '0;
            end else begin
               isiCnt_d = isiNext;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         isiCnt_q <= '0;
         spike_q  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         isiCnt_q <= isiCnt_d;
         spike_q  <= spike;
         if (accept)
            armed_q <= 1'b1;
      end
   end

   // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is not a drop.
   assign full      = count_q == FULL_CNT;
   assign isi_valid = count_q != '0;
   assign pop       = isi_valid & isi_ready;
   assign wrEn      = push & (~full | pop);
   assign drop      = push & full & ~pop;
   assign isi_data  = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wrEn) begin
            mem_q[wrPtr_q] <= isiNext;
            wrPtr_q        <= wrPtr_q + PTR_W'(1);
         end
         if (pop)
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         case ({wrEn, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
         if (drop)
            ovf_q <= 1'b1;
         else if (clr_ovf)
            ovf_q <= 1'b0;
      end
   end

   assign accNext = (accept && acc_q != '1) ? acc_q + CNT_W'(1) : acc_q;

   // An edge on the closing cycle is folded into the reported count rather than the next window.
   always_ff @(posedge clk) begin
      if (!reset) begin
         winCnt_q     <= '0;
         acc_q        <= '0;
         spikeCount_q <= '0;
         rateValid_q  <= 1'b0;
      end else if (winCnt_q == WIN_LAST) begin
         winCnt_q     <= '0;
         acc_q        <= '0;
         spikeCount_q <= accNext;
         rateValid_q  <= 1'b1;
      end else begin
         winCnt_q    <= winCnt_q + WIN_W'(1);
         acc_q       <= accNext;
         rateValid_q <= 1'b0;
      end
   end

   assign spike_count = spikeCount_q;
   assign rate_valid  = rateValid_q;
   assign ovf         = ovf_q;
   assign armed       = armed_q;

endmodule

// File: tb/tb_spike_interval_meter.sv
// Self-checking bench for spike_interval_meter: a cycle model pushes expected ISIs into a queue as spikes
// are driven, and each scenario task compares DUT outputs against it. Covers ISI_REFRACT_EN when defined.

module tb_spike_interval_meter;

   localparam int BW    = 8;
   localparam int DEPTH = 4;
   localparam int WIN   = 100;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          reset, spike, isi_ready, clr_ovf;
   logic [BW-1:0] isi_data;
   logic          isi_valid, rate_valid, ovf, armed;
   logic [CW-1:0] spike_count;
`ifdef ISI_REFRACT_EN
   logic [BW-1:0] min_isi;
   logic [7:0]    rejected_cnt;
   int            expRej;
`endif

   int            total = 0;
   int            bad = 0;
   int            cyc, lastEdge, acc, expCount;
   bit            prevSpk, mArmed, expRate, expOvf;
   logic [BW-1:0] expQ [$];

   spike_interval_meter #(.ISI_W(BW), .DEPTH(DEPTH), .WIN_CYCLES(WIN), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .spike(spike),
      .isi_data(isi_data), .isi_valid(isi_valid), .isi_ready(isi_ready),
      .spike_count(spike_count), .rate_valid(rate_valid),
      .ovf(ovf), .clr_ovf(clr_ovf),
`ifdef ISI_REFRACT_EN
      .min_isi(min_isi), .rejected_cnt(rejected_cnt),
`endif
      .armed(armed)
   );

   always #5 clk = ~clk;

   task automatic doReset();
      reset = 1'b0; spike = 1'b0; isi_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      cyc = 0; lastEdge = 0; acc = 0; expCount = 0;
      prevSpk = 0; mArmed = 0; expRate = 0; expOvf = 0;
      expQ.delete();
`ifdef ISI_REFRACT_EN
      expRej = 0;
`endif
   endtask

   // Drives one cycle of stimulus, advances the reference model, then waits past the clock edge.
   task automatic applyStimulus(input logic s, input logic r, input logic c);
      bit edgeNow, popNow, dropNow, acceptNow;
      int gap, preOcc;
      logic [BW-1:0] isiVal;
      spike = s; isi_ready = r; clr_ovf = c;
      edgeNow = s && !prevSpk;
      prevSpk = s;
      preOcc  = expQ.size();
      popNow  = (preOcc != 0) && r;
      if (popNow) void'(expQ.pop_front());
      dropNow   = 0;
      acceptNow = edgeNow;
      if (edgeNow && mArmed) begin
         gap    = cyc - lastEdge;
         isiVal = (gap > 255) ? 8'hFF : gap[7:0];
`ifdef ISI_REFRACT_EN
         if (isiVal < min_isi) begin
            acceptNow = 0;
            if (expRej != 255) expRej++;
         end
`endif
         if (acceptNow) begin
            if (preOcc == DEPTH && !popNow) dropNow = 1;
            else expQ.push_back(isiVal);
            lastEdge = cyc;
         end
      end else if (edgeNow) begin
         mArmed   = 1;
         lastEdge = cyc;
      end
      if (dropNow) expOvf = 1;
      else if (c) expOvf = 0;
      if (acceptNow && acc != 255) acc++;
      expRate = 0;
      if (cyc % WIN == WIN - 1) begin
         expCount = acc;
         acc      = 0;
         expRate  = 1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic test_reset();
      doReset();
      total++; if (isi_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", isi_valid); end
      total++; if (isi_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%0d exp=0", isi_data); end
      total++; if (spike_count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", spike_count); end
      total++; if (rate_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rate got=%b exp=0", rate_valid); end
      total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); end
      total++; if (armed !== 1'b0) begin bad++; $display("[TB] FAIL reset_armed got=%b exp=0", armed); end
      for (int c = 0; c < 10; c++) applyStimulus(c == 2 || c == 5, 1'b0, 1'b0);
      total++; if (isi_valid !== 1'b1) begin bad++; $display("[TB] FAIL premid_valid got=%b exp=1", isi_valid); end
      doReset();
      total++; if (isi_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%b exp=0", isi_valid); end
      total++; if (armed !== 1'b0) begin bad++; $display("[TB] FAIL midreset_armed got=%b exp=0", armed); end
   endtask

   task automatic test_isi_basic();
      doReset();
      for (int c = 0; c < 32; c++) begin
         applyStimulus(c == 10 || c == 15 || c == 25, 1'b1, 1'b0);
         total++; if (isi_valid !== (expQ.size() != 0)) begin bad++; $display("[TB] FAIL basic_valid cyc=%0d got=%b exp=%b", cyc, isi_valid, expQ.size() != 0); end
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL basic_data cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
         total++; if (armed !== mArmed) begin bad++; $display("[TB] FAIL basic_armed cyc=%0d got=%b exp=%b", cyc, armed, mArmed); end
         if (c == 15) begin
            total++; if (isi_data !== 8'd5) begin bad++; $display("[TB] FAIL basic_isi5 got=%0d exp=5", isi_data); end
         end
         if (c == 25) begin
            total++; if (isi_data !== 8'd10) begin bad++; $display("[TB] FAIL basic_isi10 got=%0d exp=10", isi_data); end
         end
      end
   endtask

   task automatic test_held_spike();
      doReset();
      for (int c = 0; c < 102; c++) begin
         applyStimulus((c >= 5 && c <= 24) || (c >= 32 && c <= 40), 1'b1, 1'b0);
         total++; if (isi_valid !== (expQ.size() != 0)) begin bad++; $display("[TB] FAIL held_valid cyc=%0d got=%b exp=%b", cyc, isi_valid, expQ.size() != 0); end
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL held_data cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
         if (c == 32) begin
            total++; if (isi_data !== 8'd27) begin bad++; $display("[TB] FAIL held_isi27 got=%0d exp=27", isi_data); end
         end
      end
      total++; if (spike_count !== 8'd2) begin bad++; $display("[TB] FAIL held_count got=%0d exp=2", spike_count); end
   endtask

   task automatic test_overflow();
      doReset();
      for (int c = 0; c < 36; c++) begin
         applyStimulus(c == 2 || c == 5 || c == 9 || c == 14 || c == 20 || c == 27 || c == 35, 1'b0, c == 35);
         total++; if (ovf !== expOvf) begin bad++; $display("[TB] FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, ovf, expOvf); end
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL ovf_hold cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
      end
      total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_setwins got=%b exp=1", ovf); end
      applyStimulus(1'b0, 1'b0, 1'b1);
      total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b exp=0", ovf); end
      for (int c = 0; c < 6; c++) begin
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL ovf_drain cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
         applyStimulus(1'b0, 1'b1, 1'b0);
         total++; if (isi_valid !== (expQ.size() != 0)) begin bad++; $display("[TB] FAIL ovf_valid cyc=%0d got=%b exp=%b", cyc, isi_valid, expQ.size() != 0); end
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      for (int c = 0; c < 40; c++) begin
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL b2b_data cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
         applyStimulus(c == 2 || c == 5 || c == 9 || c == 14 || c == 20 || c == 27, c == 27 || c >= 32, 1'b0);
         total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ovf cyc=%0d got=%b exp=0", cyc, ovf); end
         total++; if (isi_valid !== (expQ.size() != 0)) begin bad++; $display("[TB] FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, isi_valid, expQ.size() != 0); end
         if (c == 27) begin
            total++; if (isi_data !== 8'd4) begin bad++; $display("[TB] FAIL b2b_head got=%0d exp=4", isi_data); end
         end
      end
   endtask

   task automatic test_saturation();
      doReset();
      for (int c = 0; c < 306; c++) begin
         applyStimulus(c == 2 || c == 302, 1'b1, 1'b0);
         total++; if (isi_valid !== (expQ.size() != 0)) begin bad++; $display("[TB] FAIL sat_valid cyc=%0d got=%b exp=%b", cyc, isi_valid, expQ.size() != 0); end
         if (c == 302) begin
            total++; if (isi_data !== 8'hFF) begin bad++; $display("[TB] FAIL sat_data got=%0d exp=255", isi_data); end
         end
      end
   endtask

   task automatic test_rate_window();
      doReset();
      for (int c = 0; c < 105; c++) begin
         applyStimulus(c == 3 || c == 10 || c == 20 || c == 40 || c == 60 || c == 80 || c == 99, 1'b1, 1'b0);
         total++; if (rate_valid !== expRate) begin bad++; $display("[TB] FAIL rate_pulse cyc=%0d got=%b exp=%b", cyc, rate_valid, expRate); end
         total++; if (spike_count !== CW'(expCount)) begin bad++; $display("[TB] FAIL rate_count cyc=%0d got=%0d exp=%0d", cyc, spike_count, expCount); end
         if (c == 99) begin
            total++; if (spike_count !== 8'd7 || rate_valid !== 1'b1) begin bad++; $display("[TB] FAIL rate_close got=%0d/%b exp=7/1", spike_count, rate_valid); end
         end
      end
   endtask

`ifdef ISI_REFRACT_EN
   task automatic test_refract();
      doReset();
      min_isi = 8'd4;
      for (int c = 0; c < 35; c++) begin
         applyStimulus(c == 5 || c == 20 || c == 22 || c == 30, 1'b0, 1'b0);
         total++; if (rejected_cnt !== 8'(expRej)) begin bad++; $display("[TB] FAIL ref_rej cyc=%0d got=%0d exp=%0d", cyc, rejected_cnt, expRej); end
         if (expQ.size() != 0) begin
            total++; if (isi_data !== expQ[0]) begin bad++; $display("[TB] FAIL ref_data cyc=%0d got=%0d exp=%0d", cyc, isi_data, expQ[0]); end
         end
      end
      total++; if (rejected_cnt !== 8'd1) begin bad++; $display("[TB] FAIL ref_total got=%0d exp=1", rejected_cnt); end
      total++; if (isi_data !== 8'd15) begin bad++; $display("[TB] FAIL ref_first got=%0d exp=15", isi_data); end
      min_isi = 8'd0;
   endtask
`endif

   initial begin
`ifdef ISI_REFRACT_EN
      min_isi = 8'd0;
`endif
      $display("[TB] starting spike_interval_meter bench");
      test_reset();
      test_isi_basic();
      test_held_spike();
      test_overflow();
      test_back_to_back();
      test_saturation();
      test_rate_window();
`ifdef ISI_REFRACT_EN
      test_refract();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
